// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access.
// Data wins in IDLE; one access outstanding; fixed-latency read return.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        d_wr_q, d_wr_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_done_q, d_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_take, i_take;

    // A port is deaf during its own completion pulse so the other port gets the next slot.
    assign d_take = d_req & ~d_done_q;
    assign i_take = if_req & ~if_rvalid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_wr_d      = d_wr_q;
        if_rvalid_d = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (d_take) begin
                    state_d     = BUSY_D;
                    cnt_d       = LAT;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr & ~32'h3;
                    mem_wdata_d = d_wdata;
                    d_wr_d      = d_we;
                end else if (i_take) begin
                    state_d    = BUSY_I;
                    cnt_d      = LAT;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr & ~32'h3;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        if (!d_wr_q) d_rdata_d = mem_rdata;
                        d_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            d_wr_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_wr_q      <= d_wr_d;
            if_rvalid_q <= if_rvalid_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at latencies 2, 1 and 15.
// Three instances share stimulus; the sweep compares their timing.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic        if_rvalid, d_done, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        a_if_rvalid, a_d_done, a_mem_en, a_mem_we, a_stall_if, a_stall_mem;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_if_rvalid, b_d_done, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem)
    );

    mem_port_arbiter #(.MEM_LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_en, mem_we, if_rvalid, d_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {mem_en, mem_we, if_rvalid, d_done});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            failures++; $display("FAIL fetch_stall_T got=%b want=1", stall_if);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            failures++;
            $display("FAIL fetch_issue got=%b %b %h want=1 0 00000010", mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, stall_if} !== 2'b01) begin
            failures++; $display("FAIL fetch_busy got=%b want=01", {mem_en, stall_if});
        end
        @(negedge clk);
        mem_rdata = 32'hDEADBEEF;
        checks++;
        if ({if_rvalid, stall_if} !== 2'b01) begin
            failures++; $display("FAIL fetch_T3 got=%b want=01", {if_rvalid, stall_if});
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, stall_if, if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL fetch_done got=%b %b %h want=1 0 deadbeef", if_rvalid, stall_if, if_rdata);
        end
        if_req = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, mem_en, if_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL fetch_hold got=%b %b %h want=0 0 deadbeef", if_rvalid, mem_en, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h100}) begin
            failures++;
            $display("FAIL sim_data_grant got=%b %b %h want=1 0 00000100", mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({stall_if, stall_mem} !== 2'b11) begin
            failures++; $display("FAIL sim_stalls got=%b want=11", {stall_if, stall_mem});
        end
        @(negedge clk);
        mem_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({d_done, stall_mem, if_rvalid, d_rdata, if_rdata} !==
            {3'b100, 32'h12345678, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL sim_d_done got=%b%b%b %h %h want=100 12345678 deadbeef",
                     d_done, stall_mem, if_rvalid, d_rdata, if_rdata);
        end
        d_req = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, d_done} !== {2'b10, 32'h40, 1'b0}) begin
            failures++;
            $display("FAIL sim_fetch_grant got=%b %b %h %b want=1 0 00000040 0",
                     mem_en, mem_we, mem_addr, d_done);
        end
        @(negedge clk);
        @(negedge clk);
        mem_rdata = 32'hCAFEF00D;
        checks++;
        if (if_rvalid !== 1'b0) begin
            failures++; $display("FAIL sim_early_rvalid got=%b want=0", if_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL sim_fetch_done got=%b %h want=1 cafef00d", if_rvalid, if_rdata);
        end
        if_req = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h207; d_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h204, 32'h55}) begin
            failures++;
            $display("FAIL store_issue got=%b %b %h %h want=1 1 00000204 00000055",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        d_addr = 32'h999; d_wdata = 32'hAA;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            failures++; $display("FAIL store_one_cycle got=%b want=00", {mem_en, mem_we});
        end
        @(negedge clk);
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if ({d_done, d_rdata} !== {1'b1, 32'h12345678}) begin
            failures++;
            $display("FAIL store_done got=%b %h want=1 12345678", d_done, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if ({d_done, mem_en} !== 2'b00) begin
            failures++; $display("FAIL store_after got=%b want=00", {d_done, mem_en});
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_rvalid, d_done, mem_addr, mem_wdata, if_rdata, d_rdata}
            !== 132'd0) begin
            failures++;
            $display("FAIL abort_zero got=%b%b%b%b %h %h %h %h want=all 0",
                     mem_en, mem_we, if_rvalid, d_done, mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        rst = 1'b0; mem_rdata = 32'hBAD00BAD;
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        saw_done |= d_done;
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h80}) begin
            failures++;
            $display("FAIL first_grant got=%b %h want=1 00000080", mem_en, mem_addr);
        end
        @(negedge clk);
        saw_done |= d_done;
        @(negedge clk);
        saw_done |= d_done;
        mem_rdata = 32'h600DF00D;
        @(negedge clk);
        saw_done |= d_done;
        checks++;
        if ({if_rvalid, if_rdata, d_rdata} !== {1'b1, 32'h600DF00D, 32'd0}) begin
            failures++;
            $display("FAIL abort_fetch got=%b %h %h want=1 600df00d 00000000",
                     if_rvalid, if_rdata, d_rdata);
        end
        if_req = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        saw_done |= d_done;
        checks++;
        if (saw_done !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got=%b want=0", saw_done);
        end
    endtask

    task automatic test_latency_sweep();
        int en_c[3][3];
        int rv_c[3][2];
        int ne[3];
        int nr[3];
        logic [2:0] ev, rv;
        for (int i = 0; i < 3; i++) begin
            ne[i] = 0; nr[i] = 0;
            for (int j = 0; j < 3; j++) en_c[i][j] = -1;
            for (int j = 0; j < 2; j++) rv_c[i][j] = -1;
        end
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            ev = {b_mem_en, a_mem_en, mem_en};
            rv = {b_if_rvalid, a_if_rvalid, if_rvalid};
            for (int i = 0; i < 3; i++) begin
                if (ev[i] && ne[i] < 3) begin en_c[i][ne[i]] = k; ne[i]++; end
                if (rv[i] && nr[i] < 2) begin rv_c[i][nr[i]] = k; nr[i]++; end
            end
        end
        if_req = 1'b0;
        checks++;
        if ({rv_c[0][0], rv_c[1][0], rv_c[2][0]} !== {32'sd4, 32'sd3, 32'sd17}) begin
            failures++;
            $display("FAIL sweep_first_done got=%0d %0d %0d want=4 3 17",
                     rv_c[0][0], rv_c[1][0], rv_c[2][0]);
        end
        checks++;
        if ({en_c[0][0], en_c[1][0], en_c[2][0]} !== {32'sd1, 32'sd1, 32'sd1}) begin
            failures++;
            $display("FAIL sweep_first_en got=%0d %0d %0d want=1 1 1",
                     en_c[0][0], en_c[1][0], en_c[2][0]);
        end
        checks++;
        if ({en_c[0][1], en_c[0][2], en_c[1][1], en_c[1][2], en_c[2][1], en_c[2][2]} !==
            {32'sd6, 32'sd11, 32'sd5, 32'sd9, 32'sd19, 32'sd37}) begin
            failures++;
            $display("FAIL sweep_b2b_en got=L2 %0d %0d L1 %0d %0d L15 %0d %0d want=6 11 5 9 19 37",
                     en_c[0][1], en_c[0][2], en_c[1][1], en_c[1][2], en_c[2][1], en_c[2][2]);
        end
        checks++;
        if ({rv_c[0][1], rv_c[1][1], rv_c[2][1]} !== {32'sd9, 32'sd7, 32'sd35}) begin
            failures++;
            $display("FAIL sweep_second_done got=%0d %0d %0d want=9 7 35",
                     rv_c[0][1], rv_c[1][1], rv_c[2][1]);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_store();
        test_reset_abort();
        test_latency_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 2: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port if_req, input, 1 bit: fetch request, level, held until if_rvalid.
REQ-005 The block SHALL have port if_addr, input, 32 bits: fetch address (PC).
REQ-006 The block SHALL have port if_rvalid, output, 1 bit: one-cycle fetch completion pulse.
REQ-007 The block SHALL have port if_rdata, output, 32 bits: fetched instr32, registered.
REQ-008 The block SHALL have port d_req, input, 1 bit: MEM-stage LW/SW request, level, held until d_done.
REQ-009 The block SHALL have port d_we, input, 1 bit: DataMem_sel_e (Read=0, Write=1).
REQ-010 The block SHALL have port d_addr, input, 32 bits: ALU_Result address.
REQ-011 The block SHALL have port d_wdata, input, 32 bits: store data (Rs2).
REQ-012 The block SHALL have port d_done, output, 1 bit: one-cycle data completion pulse.
REQ-013 The block SHALL have port d_rdata, output, 32 bits: load data, registered.
REQ-014 The block SHALL have port mem_en, output, 1 bit: memory access strobe, one cycle per access.
REQ-015 The block SHALL have port mem_we, output, 1 bit: write enable, valid with mem_en.
REQ-016 The block SHALL have port mem_addr, output, 32 bits: word address, bits [1:0] forced to 0.
REQ-017 The block SHALL have port mem_wdata, output, 32 bits: write data.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: read data, valid MEM_LATENCY cycles after mem_en.
REQ-019 The block SHALL have port stall_if, output, 1 bit: if_req & ~if_rvalid, combinational.
REQ-020 The block SHALL have port stall_mem, output, 1 bit: d_req & ~d_done, combinational.

Function
REQ-021 The block SHALL implement FSM states IDLE, BUSY_I and BUSY_D, and a 4-bit down-counter cnt.
REQ-022 In IDLE, a sampled d_req SHALL take priority over a sampled if_req; a granted request moves the FSM to BUSY_D or BUSY_I respectively at the next edge.
REQ-023 A port's request SHALL be ignored in the cycle that port's completion pulse (if_rvalid/d_done) is high; this guarantees that after a data access with if_req pending, fetch is granted next.
REQ-024 mem_en, mem_we, mem_addr and mem_wdata SHALL be registered, asserted in the first BUSY cycle only.
  - mem_we is forced to 0 for fetch.
  - Address and data are captured at grant; later input changes are ignored.
REQ-025 cnt SHALL be MEM_LATENCY in the mem_en cycle, decrement by 1 each BUSY cycle, and never wrap below 0.
REQ-026 In the BUSY cycle with cnt==0:
  - mem_rdata SHALL be captured into if_rdata (BUSY_I) or d_rdata (BUSY_D read).
  - The FSM SHALL return to IDLE.
  - The completion pulse SHALL be high in the following cycle.
REQ-027 Latency: a request sampled in IDLE at cycle T SHALL complete with its pulse at cycle T+2+MEM_LATENCY; MEM_LATENCY=2 gives T+4.
REQ-028 For stores, d_done SHALL pulse with the same timing as loads, and d_rdata SHALL hold its prior value.
REQ-029 if_rdata and d_rdata SHALL hold their values between completions.
REQ-030 At most one access SHALL be outstanding at any time; no mem_en is issued in BUSY states.
REQ-031 Requests arriving in BUSY states SHALL wait, with their stall output high, and be arbitrated on return to IDLE.

Reset
REQ-032 While rst=1 at an edge, the block SHALL enter IDLE with cnt=0 and mem_en, mem_we, if_rvalid, d_done=0, and mem_addr, mem_wdata, if_rdata, d_rdata=0.
REQ-033 Reset mid-access SHALL abort the access with no completion pulse; a late mem_rdata is ignored.
REQ-034 The first grant SHALL be possible in the first cycle with rst=0.

Verification
REQ-035 Lone fetch test: if_req=1, if_addr=0x10 at T -> mem_en=1, mem_addr=0x10, mem_we=0 at T+1; mem_rdata=0xDEADBEEF at T+3 -> if_rvalid=1, if_rdata=0xDEADBEEF at T+4; stall_if=1 during T..T+3.
REQ-036 Simultaneous requests: if_req and d_req (LW, 0x100) both high at T -> data granted (mem_addr=0x100 at T+1); d_done at T+4; fetch mem_en at T+5; if_rvalid at T+8.
REQ-037 Store: d_we=1, d_addr=0x207, d_wdata=0x55 -> mem_we=1, mem_addr=0x204, mem_wdata=0x55 for one cycle; d_done pulses; d_rdata unchanged.
REQ-038 Reset abort: rst=1 for one cycle during BUSY_D with cnt=1 -> IDLE next cycle; d_done never pulses; all outputs 0.
REQ-039 Latency sweep: MEM_LATENCY=1 and 15 -> completion exactly at T+3 and T+17; back-to-back fetches issue mem_en every MEM_LATENCY+3 cycles.
